ram_mux_sequencer: RTL and testbench
====================================

Name: ram_mux_sequencer

Overview:
Parametrised arbiter/sequencer granting exclusive access to one synchronous single-port RAM among NUM_DEVICES RC4 engines (initializer, shuffler, decryptor, ...).
- Launches a selected device, or a chain of devices in index order, with a one-cycle start pulse.
- Muxes the active device onto the RAM port and drains outstanding reads before hand-off.
- Routes read-data-valid back to the issuing device.
- Sits between the top-level control FSM and the RAM.

Parameters:
RAM_WIDTH, 8, RAM data width
ADDR_WIDTH, 8, RAM address width
NUM_DEVICES, 4, number of attached engines (>=2)
RD_LATENCY, 1, RAM read latency in cycles (>=1)
SEL_WIDTH, $clog2(NUM_DEVICES), derived; device index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin an operation
dev_sel  in  SEL_WIDTH  first (or only) device to run
chain  in  1  1: run dev_sel..NUM_DEVICES-1 in order; 0: run dev_sel only
abort  in  1  terminate current operation
busy  out  1  high from accepted start until return to IDLE
done  out  1  one-cycle pulse on normal completion
err  out  1  one-cycle pulse on start with dev_sel >= NUM_DEVICES
active_dev  out  SEL_WIDTH  index of the device currently owning the RAM
dev_start  out  NUM_DEVICES  one-hot start pulse per device
dev_finished  in  NUM_DEVICES  per-device completion pulse
dev_we  in  NUM_DEVICES  per-device write enable
dev_re  in  NUM_DEVICES  per-device read strobe
dev_addr  in  NUM_DEVICES*ADDR_WIDTH  packed per-device addresses
dev_wdata  in  NUM_DEVICES*RAM_WIDTH  packed per-device write data
dev_rdata  out  RAM_WIDTH  RAM read data, broadcast to all devices
dev_rvalid  out  NUM_DEVICES  one-hot read-data-valid to the issuing device
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_WIDTH  RAM address
ram_wdata  out  RAM_WIDTH  RAM write data
ram_rdata  in  RAM_WIDTH  RAM read data

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs 0; active_dev=0; rvalid pipeline cleared.
- IDLE:
  - start=1 and dev_sel<NUM_DEVICES: latch cur<=dev_sel and chain_r<=chain; go to LAUNCH; busy=1 from the next cycle.
  - start=1 and dev_sel invalid: err pulse next cycle; stay in IDLE.
- LAUNCH: dev_start[cur]=1 for exactly this cycle; RAM port idle (we=0); dev_finished ignored. Go to RUN.
- RUN:
  - ram_we/ram_addr/ram_wdata = device cur's signals, combinational.
  - Signals from all other devices are ignored.
  - dev_finished[cur]=1 -> DRAIN. A write presented in the same cycle still reaches the RAM.
  - dev_finished from non-active devices is ignored.
- DRAIN: RAM port forced idle for exactly RD_LATENCY cycles (counter). Then:
  - chain_r=1 and cur<NUM_DEVICES-1: cur<=cur+1, go to LAUNCH.
  - Otherwise: go to DONE.
- DONE: done=1 for one cycle; busy drops; go to IDLE.
- Outside RUN: ram_we=0, ram_addr=0, ram_wdata=0.
- Read path:
  - dev_re[cur] sampled in RUN enters a RD_LATENCY-deep pipeline of {valid, owner}.
  - dev_rvalid[owner] asserts exactly RD_LATENCY cycles later.
  - dev_rdata = ram_rdata at all times.
  - A read issued in the finishing cycle completes during DRAIN.
- active_dev = cur while busy, else 0.
- abort=1 in any non-IDLE state: next state IDLE, pipeline flushed, no done, busy=0 next cycle. abort in IDLE has no effect.
- start while busy is ignored. start and abort together in IDLE: start is accepted.

Decomposition:
- Package ram_ctrl_pkg:
  - state enum {IDLE, LAUNCH, RUN, DRAIN, DONE}.
  - Helper function for one-hot decode of SEL_WIDTH indices.
- Sub-module rd_valid_pipe: RD_LATENCY shift register of {valid, owner}, with synchronous flush and async active-low reset.
- Top-level: FSM, drain counter, output mux.

Test Plan:
- Single run: NUM_DEVICES=4. start, dev_sel=0, chain=0 -> dev_start=4'b0001 one cycle later. Device 0's writes to addr 0..255 reach the RAM. After dev_finished[0], the port is idle for 1 cycle, done pulses, busy=0.
- Chain: dev_sel=1, chain=1 -> dev_start pulses 0010, 0100, 1000 in order, each after the prior finish + RD_LATENCY + 1 cycles. Exactly one done.
- Read routing: RD_LATENCY=2, device 2 reads addr 0x10 (RAM holds 0xA5) -> dev_rvalid=4'b0100 two cycles later, dev_rdata=0xA5. Other dev_rvalid bits stay 0.
- Isolation: device 3 drives we=1, addr=0x55 while device 1 is active -> RAM not written. A stray dev_finished[3] does not change state.
- Error/abort: dev_sel=5 with NUM_DEVICES=4 -> err pulse, busy stays 0. Abort in RUN -> ram_we=0 and busy=0 next cycle, no done, no rvalid afterwards.
- Reset mid-chain: reset=0 asynchronously during DRAN of device 1 -> all outputs 0 immediately. After release, a new start behaves as after power-up.

Source files
------------

// File: rtl/ram_mux_sequencer_pkg.sv
// Shared types and helpers for the RAM arbiter/sequencer.
// FSM state encoding and a one-hot index decode used by the muxes.
package ram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    DRAIN,
    DONE
  } state_e;

  function automatic logic oh_bit(
    input int unsigned idx,
    input int unsigned k
  );
    return idx == k;
  endfunction

endpackage

// File: rtl/ram_mux_sequencer_if.sv
// Control, per-device and RAM-side signals of the sequencer.
// master is the sequencer's view; slave is the surrounding system.
interface ram_mux_sequencer_if #(
  parameter int RAM_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_DEVICES = 4,
  parameter int SEL_WIDTH   = $clog2(NUM_DEVICES)
);

  logic                              start;
  logic [SEL_WIDTH-1:0]              dev_sel;
  logic                              chain;
  logic                              abort;
  logic                              busy;
  logic                              done;
  logic                              err;
  logic [SEL_WIDTH-1:0]              active_dev;
  logic [NUM_DEVICES-1:0]            dev_start;
  logic [NUM_DEVICES-1:0]            dev_finished;
  logic [NUM_DEVICES-1:0]            dev_we;
  logic [NUM_DEVICES-1:0]            dev_re;
  logic [NUM_DEVICES*ADDR_WIDTH-1:0] dev_addr;
  logic [NUM_DEVICES*RAM_WIDTH-1:0]  dev_wdata;
  logic [RAM_WIDTH-1:0]              dev_rdata;
  logic [NUM_DEVICES-1:0]            dev_rvalid;
  logic                              ram_we;
  logic [ADDR_WIDTH-1:0]             ram_addr;
  logic [RAM_WIDTH-1:0]              ram_wdata;
  logic [RAM_WIDTH-1:0]              ram_rdata;

  modport master (
    input  start, dev_sel, chain, abort,
    input  dev_finished, dev_we, dev_re,
    input  dev_addr, dev_wdata, ram_rdata,
    output busy, done, err, active_dev,
    output dev_start, dev_rdata, dev_rvalid,
    output ram_we, ram_addr, ram_wdata
  );

  modport slave (
    output start, dev_sel, chain, abort,
    output dev_finished, dev_we, dev_re,
    output dev_addr, dev_wdata, ram_rdata,
    input  busy, done, err, active_dev,
    input  dev_start, dev_rdata, dev_rvalid,
    input  ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/ram_mux_sequencer_rd_valid_pipe.sv
// Delay line of {valid, owner} matching the RAM read latency.
// Flush kills reads in flight when an operation is aborted.
module rd_valid_pipe #(
  parameter int DEPTH = 1,
  parameter int OW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [OW-1:0] in_owner,
  output logic          out_valid,
  output logic [OW-1:0] out_owner
);

  logic [DEPTH-1:0]         vld_q, vld_d;
  logic [DEPTH-1:0][OW-1:0] own_q, own_d;

  always_comb begin
    vld_d = vld_q;
    own_d = own_q;
    if (flush) begin
      vld_d = '0;
      own_d = '0;
    end else begin
      vld_d[0] = in_valid;
      own_d[0] = in_owner;
      for (int i = 1; i < DEPTH; i++) begin
        vld_d[i] = vld_q[i-1];
        own_d[i] = own_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q <= vld_d;
      own_q <= own_d;
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_owner = own_q[DEPTH-1];

endmodule

// File: rtl/ram_mux_sequencer.sv
// Grants one single-port RAM to a sequence of RC4 engines in turn,
// draining outstanding reads before each hand-off.
module ram_mux_sequencer
  import ram_ctrl_pkg::*;
#(
  parameter int RAM_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_DEVICES = 4,
  parameter int RD_LATENCY  = 1,
  parameter int SEL_WIDTH   = $clog2(NUM_DEVICES)
) (
  input logic                 clk,
  input logic                 reset,
  ram_mux_sequencer_if.master bus
);

  localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(RD_LATENCY - 1);
  localparam logic [SEL_WIDTH-1:0] TOP = SEL_WIDTH'(NUM_DEVICES - 1);

  state_e               state_q, state_d;
  logic [SEL_WIDTH-1:0] cur_q, cur_d;
  logic                 chain_q, chain_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic                  sel_ok, run, busy;
  logic                  flush, rd_in, rd_vld;
  logic [SEL_WIDTH-1:0]  rd_own;
  logic                  fin_cur, we_cur, re_cur;
  logic [ADDR_WIDTH-1:0] addr_cur;
  logic [RAM_WIDTH-1:0]  wdata_cur;

  always_comb begin
    fin_cur   = 1'b0;
    we_cur    = 1'b0;
    re_cur    = 1'b0;
    addr_cur  = '0;
    wdata_cur = '0;
    for (int k = 0; k < NUM_DEVICES; k++) begin
      if (oh_bit(32'(cur_q), 32'(k))) begin
        fin_cur   = bus.dev_finished[k];
        we_cur    = bus.dev_we[k];
        re_cur    = bus.dev_re[k];
        addr_cur  = bus.dev_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_cur = bus.dev_wdata[k*RAM_WIDTH +: RAM_WIDTH];
      end
    end
  end

  assign sel_ok = int'({1'b0, bus.dev_sel}) < NUM_DEVICES;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    chain_d = chain_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (sel_ok) begin
            state_d = LAUNCH;
            cur_d   = bus.dev_sel;
            chain_d = bus.chain;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LAUNCH: state_d = RUN;
      RUN: begin
        if (fin_cur) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (cnt_q == LAST) begin
          if (chain_q && (cur_q < TOP)) begin
            cur_d   = cur_q + SEL_WIDTH'(1);
            state_d = LAUNCH;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // abort wins over every transition except a start from IDLE
    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      chain_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign run   = state_q == RUN;
  assign busy  = (state_q == LAUNCH) || run || (state_q == DRAIN);
  assign flush = bus.abort && (state_q != IDLE);
  assign rd_in = run && re_cur;

  rd_valid_pipe #(
    .DEPTH (RD_LATENCY),
    .OW    (SEL_WIDTH)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (flush),
    .in_valid  (rd_in),
    .in_owner  (cur_q),
    .out_valid (rd_vld),
    .out_owner (rd_own)
  );

  always_comb begin
    bus.busy       = busy;
    bus.done       = state_q == DONE;
    bus.err        = err_q;
    bus.active_dev = busy ? cur_q : '0;
    bus.ram_we     = run && we_cur;
    bus.ram_addr   = run ? addr_cur : '0;
    bus.ram_wdata  = run ? wdata_cur : '0;
    bus.dev_rdata  = bus.ram_rdata;
    bus.dev_start  = '0;
    bus.dev_rvalid = '0;
    for (int k = 0; k < NUM_DEVICES; k++) begin
      bus.dev_start[k] = (state_q == LAUNCH) &&
                         oh_bit(32'(cur_q), 32'(k));
      bus.dev_rvalid[k] = rd_vld &&
                          oh_bit(32'(rd_own), 32'(k));
    end
  end

endmodule

// File: tb/tb_ram_mux_sequencer.sv
// Directed bench: cycle table for sequencing/isolation/abort,
// plus hand sequences for RAM sweep, read routing and reset.
module tb_ram_mux_sequencer;

  localparam int N   = 4;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int SW  = 3;
  localparam int LAT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ram_mux_sequencer_if #(
    .RAM_WIDTH   (DW),
    .ADDR_WIDTH  (AW),
    .NUM_DEVICES (N),
    .SEL_WIDTH   (SW)
  ) bus_if ();

  ram_mux_sequencer #(
    .RAM_WIDTH   (DW),
    .ADDR_WIDTH  (AW),
    .NUM_DEVICES (N),
    .RD_LATENCY  (LAT),
    .SEL_WIDTH   (SW)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_if.master)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [7:0] rd1;

  always @(posedge clk) begin
    if (bus_if.ram_we) mem[bus_if.ram_addr] <= bus_if.ram_wdata;
    rd1              <= mem[bus_if.ram_addr];
    bus_if.ram_rdata <= rd1;
  end

  typedef struct {
    logic       start;
    logic [2:0] sel;
    logic       chain;
    logic       abort;
    logic [3:0] fin;
    logic [3:0] we;
    logic [3:0] re;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] adev;
    logic [3:0] ds;
    logic [3:0] rv;
    logic       rwe;
    logic [7:0] raddr;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  function automatic logic [22:0] outs();
    return {bus_if.busy, bus_if.done, bus_if.err, bus_if.active_dev,
            bus_if.dev_start, bus_if.dev_rvalid, bus_if.ram_we,
            bus_if.ram_addr};
  endfunction

  function automatic vec_t mk(
    logic s, logic [2:0] sel, logic ch, logic ab,
    logic [3:0] fin, logic [3:0] we, logic [3:0] re,
    logic bsy, logic dn, logic er, logic [2:0] ad,
    logic [3:0] ds, logic [3:0] rv, logic rwe, logic [7:0] ra
  );
    vec_t v;
    v.start = s;   v.sel = sel; v.chain = ch; v.abort = ab;
    v.fin = fin;   v.we = we;   v.re = re;
    v.busy = bsy;  v.done = dn; v.err = er;   v.adev = ad;
    v.ds = ds;     v.rv = rv;   v.rwe = rwe;  v.raddr = ra;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus_if.start        = 1'b0;
    bus_if.dev_sel      = '0;
    bus_if.chain        = 1'b0;
    bus_if.abort        = 1'b0;
    bus_if.dev_finished = '0;
    bus_if.dev_we       = '0;
    bus_if.dev_re       = '0;
  endtask

  task automatic set_dev(int k, logic [7:0] a, logic [7:0] d);
    bus_if.dev_addr[k*AW +: AW]  = a;
    bus_if.dev_wdata[k*DW +: DW] = d;
  endtask

  task automatic go(logic [2:0] sel, logic ch);
    bus_if.start   = 1'b1;
    bus_if.dev_sel = sel;
    bus_if.chain   = ch;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int bad;
    vec_t v;
    idle_in();
    bus_if.dev_addr  = '0;
    bus_if.dev_wdata = '0;

    // ---- reset ----
    repeat (2) tick();
    chk("reset_outs", outs(), '0);
    rst_n = 1'b1;
    tick();
    chk("idle_outs", outs(), '0);

    // ---- single run: device 0 sweeps all addresses ----
    go(3'd0, 1'b0);
    tick();
    idle_in();
    #3 chk("sweep_launch", {bus_if.busy, bus_if.dev_start, bus_if.ram_we},
           {1'b1, 4'b0001, 1'b0});
    for (int i = 0; i < 256; i++) begin
      tick();
      bus_if.dev_we[0]       = 1'b1;
      bus_if.dev_finished[0] = (i == 255);
      set_dev(0, 8'(i), 8'(i) ^ 8'h3C);
    end
    tick();
    idle_in();
    #3 chk("sweep_drain1", {bus_if.ram_we, bus_if.busy, bus_if.done}, 3'b010);
    tick();
    #3 chk("sweep_drain2", {bus_if.ram_we, bus_if.busy, bus_if.done}, 3'b010);
    tick();
    #3 chk("sweep_done", {bus_if.busy, bus_if.done}, 2'b01);
    tick();
    #3 chk("sweep_idle", {bus_if.busy, bus_if.done}, 2'b00);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== (8'(i) ^ 8'h3C)) bad++;
    chk("sweep_mem", 64'(bad), 64'd0);

    // ---- cycle table ----
    set_dev(0, 8'h01, 8'hA0);
    set_dev(1, 8'h12, 8'hA1);
    set_dev(2, 8'h23, 8'hA2);
    set_dev(3, 8'h55, 8'hA3);
    tbl.push_back(mk(1,0,0,0, 4'h0,4'h0,4'h0, 0,0,0,0,4'h0,4'h0,0,8'h00));
    tbl.push_back(mk(0,0,0,0, 4'h1,4'h1,4'h0, 1,0,0,0,4'h1,4'h0,0,8'h00));
    tbl.push_back(mk(0,0,0,0, 4'h0,4'h1,4'h0, 1,0,0,0,4'h0,4'h0,1,8'h01));
    tbl.push_back(mk(0,0,0,0, 4'h8,4'h8,4'h0, 1,0,0,0,4'h0,4'h0,0,8'h01));
    tbl.push_back(mk(0,0,0,0, 4'h1,4'h1,4'h1, 1,0,0,0,4'h0,4'h0,1,8'h01));
    tbl.push_back(mk(0,0,0,0, 4'h0,4'h0,4'h0, 1,0,0,0,4'h0,4'h0,0,8'h00));
    tbl.push_back(mk(0,0,0,0, 4'h0,4'h0,4'h0, 1,0,0,0,4'h0,4'h1,0,8'h00));
    tbl.push_back(mk(0,0,0,0, 4'h0,4'h0,4'h0, 0,1,0,0,4'h0,4'h0,0,8'h00));
    tbl.push_back(mk(1,5,0,0, 4'h0,4'h0,4'h0, 0,0,0,0,4'h0,4'h0,0,8'h00));
    tbl.push_back(mk(0,0,0,0, 4'h0,4'h0,4'h0, 0,0,1,0,4'h0,4'h0,0,8'h00));
    tbl.push_back(mk(1,1,1,1, 4'h0,4'h0,4'h0, 0,0,0,0,4'h0,4'h0,0,8'h00));
    tbl.push_back(mk(0,0,0,0, 4'h0,4'h0,4'h0, 1,0,0,1,4'h2,4'h0,0,8'h00));
    tbl.push_back(mk(0,0,0,0, 4'h0,4'h2,4'h4, 1,0,0,1,4'h0,4'h0,1,8'h12));
    tbl.push_back(mk(1,0,0,0, 4'h2,4'h0,4'h0, 1,0,0,1,4'h0,4'h0,0,8'h12));
    tbl.push_back(mk(0,0,0,0, 4'h0,4'h0,4'h0, 1,0,0,1,4'h0,4'h0,0,8'h00));
    tbl.push_back(mk(0,0,0,0, 4'h0,4'h0,4'h0, 1,0,0,1,4'h0,4'h0,0,8'h00));
    tbl.push_back(mk(0,0,0,0, 4'h0,4'h0,4'h0, 1,0,0,2,4'h4,4'h0,0,8'h00));
    tbl.push_back(mk(0,0,0,0, 4'h4,4'h0,4'h4, 1,0,0,2,4'h0,4'h0,0,8'h23));
    tbl.push_back(mk(0,0,0,0, 4'h0,4'h0,4'h0, 1,0,0,2,4'h0,4'h0,0,8'h00));
    tbl.push_back(mk(0,0,0,0, 4'h0,4'h0,4'h0, 1,0,0,2,4'h0,4'h4,0,8'h00));
    tbl.push_back(mk(0,0,0,0, 4'h0,4'h0,4'h0, 1,0,0,3,4'h8,4'h0,0,8'h00));
    tbl.push_back(mk(0,0,0,0, 4'h8,4'h0,4'h0, 1,0,0,3,4'h0,4'h0,0,8'h55));
    tbl.push_back(mk(0,0,0,0, 4'h0,4'h0,4'h0, 1,0,0,3,4'h0,4'h0,0,8'h00));
    tbl.push_back(mk(0,0,0,0, 4'h0,4'h0,4'h0, 1,0,0,3,4'h0,4'h0,0,8'h00));
    tbl.push_back(mk(0,0,0,0, 4'h0,4'h0,4'h0, 0,1,0,0,4'h0,4'h0,0,8'h00));
    tbl.push_back(mk(1,2,0,0, 4'h0,4'h0,4'h0, 0,0,0,0,4'h0,4'h0,0,8'h00));
    tbl.push_back(mk(0,0,0,0, 4'h0,4'h0,4'h0, 1,0,0,2,4'h4,4'h0,0,8'h00));
    tbl.push_back(mk(0,0,0,1, 4'h0,4'h0,4'h4, 1,0,0,2,4'h0,4'h0,0,8'h23));
    tbl.push_back(mk(0,0,0,0, 4'h0,4'h0,4'h0, 0,0,0,0,4'h0,4'h0,0,8'h00));
    tbl.push_back(mk(0,0,0,0, 4'h0,4'h0,4'h0, 0,0,0,0,4'h0,4'h0,0,8'h00));
    tbl.push_back(mk(0,0,0,1, 4'h0,4'h0,4'h0, 0,0,0,0,4'h0,4'h0,0,8'h00));
    tbl.push_back(mk(0,0,0,0, 4'h0,4'h0,4'h0, 0,0,0,0,4'h0,4'h0,0,8'h00));
    foreach (tbl[i]) begin
      v = tbl[i];
      tick();
      bus_if.start        = v.start;
      bus_if.dev_sel      = v.sel;
      bus_if.chain        = v.chain;
      bus_if.abort        = v.abort;
      bus_if.dev_finished = v.fin;
      bus_if.dev_we       = v.we;
      bus_if.dev_re       = v.re;
      #3 chk($sformatf("row%0d", i), 64'(outs()),
             64'({v.busy, v.done, v.err, v.adev, v.ds, v.rv,
                  v.rwe, v.raddr}));
    end
    idle_in();
    chk("isolate_mem55", 64'(mem[8'h55]), 64'h69);
    chk("dev0_wr", 64'(mem[8'h01]), 64'hA0);
    chk("dev1_wr", 64'(mem[8'h12]), 64'hA1);

    // ---- read routing, device 2 ----
    set_dev(2, 8'h10, 8'hA5);
    tick();
    go(3'd2, 1'b0);
    tick();
    idle_in();
    tick();
    bus_if.dev_we[2] = 1'b1;
    tick();
    bus_if.dev_we[2] = 1'b0;
    bus_if.dev_re[2] = 1'b1;
    tick();
    bus_if.dev_re[2] = 1'b0;
    #3 chk("rd_early", 64'(bus_if.dev_rvalid), 64'h0);
    tick();
    bus_if.dev_re[2]       = 1'b1;
    bus_if.dev_finished[2] = 1'b1;
    #3 chk("rd_valid", 64'({bus_if.dev_rvalid, bus_if.dev_rdata}),
           64'({4'b0100, 8'hA5}));
    tick();
    idle_in();
    #3 chk("rd_gap", 64'(bus_if.dev_rvalid), 64'h0);
    tick();
    #3 chk("rd_in_drain", 64'({bus_if.dev_rvalid, bus_if.dev_rdata,
                               bus_if.busy}),
           64'({4'b0100, 8'hA5, 1'b1}));
    tick();
    #3 chk("rd_done", 64'({bus_if.done, bus_if.dev_rvalid}), 64'h10);

    // ---- asynchronous reset mid-chain ----
    set_dev(2, 8'h23, 8'hA2);
    tick();
    go(3'd0, 1'b1);
    tick();
    idle_in();
    tick();
    bus_if.dev_finished[0] = 1'b1;
    tick();
    idle_in();
    repeat (2) tick();
    tick();
    bus_if.dev_finished[1] = 1'b1;
    bus_if.dev_re[1]       = 1'b1;
    tick();
    idle_in();
    chk("pre_reset", 64'({bus_if.busy, bus_if.active_dev}),
        64'({1'b1, 3'd1}));
    #1 rst_n = 1'b0;
    #1 chk("reset_async", 64'(outs()), 64'h0);
    repeat (2) tick();
    #1 rst_n = 1'b1;
    tick();
    #3 chk("post_reset", 64'(outs()), 64'h0);
    tick();
    go(3'd3, 1'b0);
    tick();
    idle_in();
    #3 chk("restart_launch",
           64'({bus_if.busy, bus_if.active_dev, bus_if.dev_start}),
           64'({1'b1, 3'd3, 4'b1000}));
    tick();
    bus_if.dev_finished[3] = 1'b1;
    tick();
    idle_in();
    repeat (2) tick();
    #3 chk("restart_done", 64'({bus_if.done, bus_if.busy}), 64'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
